// File: rtl/stream_demux_pkg.sv
// Shared defaults and width helpers for the two-way stream demultiplexer.
package stream_demux_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultDepth = 2;
  localparam int unsigned PTR_W        = $clog2(DefaultDepth) + 1;
  localparam int unsigned CNT_W        = 8;

  // One extra pointer bit distinguishes full from empty.
  function automatic int unsigned ptr_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head data reads as zero when empty.
module sync_fifo
  import stream_demux_pkg::*;
#(
  parameter int unsigned DataW = DefaultDataW,
  parameter int unsigned Depth = DefaultDepth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [DataW-1:0] data_o
);

  localparam int unsigned PtrW = ptr_width(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [PtrW-1:0]  rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PtrW-1] != rd_q[PtrW-1]) && (wr_q[PtrW-2:0] == rd_q[PtrW-2:0]);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[PtrW-2:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PtrW'(1);
    if (do_pop)  rd_d = rd_q + PtrW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[PtrW-2:0]] <= data_i;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Routes each input beat to one of two buffered output ports by in_sel_i,
// counting accepted beats per port.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = DefaultDepth
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sel_i,
  output logic              out0_valid_o,
  input  logic              out0_ready_i,
  output logic [DATA_W-1:0] out0_data_o,
  output logic              out1_valid_o,
  input  logic              out1_ready_i,
  output logic [DATA_W-1:0] out1_data_o,
  output logic [CNT_W-1:0]  cnt0_o,
  output logic [CNT_W-1:0]  cnt1_o
);

  logic [1:0]       full, empty, push, pop;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // No full-bypass: a pop in the same cycle does not make a full FIFO ready.
  assign in_ready_o = ~reset & ~full[in_sel_i];

  assign push[0] = in_valid_i & in_ready_o & ~in_sel_i;
  assign push[1] = in_valid_i & in_ready_o &  in_sel_i;
  assign pop[0]  = out0_ready_i & ~empty[0];
  assign pop[1]  = out1_ready_i & ~empty[1];

  assign out0_valid_o = ~empty[0];
  assign out1_valid_o = ~empty[1];

  sync_fifo #(
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_fifo0 (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push[0]),
    .data_i  (in_data_i),
    .pop_i   (pop[0]),
    .full_o  (full[0]),
    .empty_o (empty[0]),
    .data_o  (out0_data_o)
  );

  sync_fifo #(
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_fifo1 (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push[1]),
    .data_i  (in_data_i),
    .pop_i   (pop[1]),
    .full_o  (full[1]),
    .empty_o (empty[1]),
    .data_o  (out1_data_o)
  );

  always_comb begin
    cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, push[0]};
    cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, push[1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0_o = cnt0_q;
  assign cnt1_o = cnt1_q;

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, entries per output FIFO (power of two, >=2).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid_i  input  1  input beat present.
REQ-007 in_ready_o  output  1  block can accept the beat presented this cycle.
REQ-008 in_data_i  input  DATA_W  input payload.
REQ-009 in_sel_i  input  1  destination: 0 routes to out0, 1 routes to out1.
REQ-010 out0_valid_o / out1_valid_o  output  1  output port holds a beat.
REQ-011 out0_ready_i / out1_ready_i  input  1  downstream consumes the beat.
REQ-012 out0_data_o / out1_data_o  output  DATA_W  head-of-FIFO payload.
REQ-013 cnt0_o / cnt1_o  output  8  beats accepted for each port, modulo 256.

Function
REQ-014 The block SHALL accept an input beat when in_valid_i && in_ready_o on a rising clk edge.
REQ-015 in_ready_o SHALL equal NOT full of the FIFO selected by in_sel_i; it is combinational from in_sel_i and FIFO state.
REQ-016 in_ready_o SHALL be 0 while reset is 1.
REQ-017 An accepted beat SHALL be written to FIFO[in_sel_i] only; the other FIFO SHALL be unchanged.
REQ-018 Latency: a beat accepted at edge N into an empty FIFO SHALL appear on outK_valid_o/outK_data_o after edge N (same-cycle pass-through not permitted).
REQ-019 Each output SHALL pop its head when outK_valid_o && outK_ready_i at a rising edge.
REQ-020 outK_data_o SHALL be stable while outK_valid_o=1 and outK_ready_i=0.
REQ-021 Beats SHALL leave each port in acceptance order; no ordering between ports is implied.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged and preserve order.
REQ-023 Simultaneous push and pop on an empty FIFO SHALL not occur (valid=0); the push SHALL succeed.
REQ-024 Full FIFO: in_ready_o=0 for that sel even if the same-cycle pop would free a slot (no full-bypass).
REQ-025 Backpressure on one port SHALL NOT block beats addressed to the other port.
REQ-026 in_valid_i=1 with in_ready_o=0 SHALL not change any state; the source holds data/sel.
REQ-027 cntK_o SHALL increment by 1 per beat accepted for port K and wrap 255 -> 0.
REQ-028 FIFO pointers SHALL be log2(DEPTH)+1 bits; full when pointers differ only in MSB, empty when equal.

Reset
REQ-029 On reset=1 at a rising edge: both FIFOs empty, out0_valid_o=out1_valid_o=0, out0_data_o=out1_data_o=0, cnt0_o=cnt1_o=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered beats; no beat is output in the cycle after reset.
REQ-031 An input handshake coincident with reset SHALL be discarded and not counted.

Structure
REQ-032 Package stream_demux_pkg SHALL hold DATA_W and DEPTH defaults, pointer-width localparam PTR_W, and the count width constant CNT_W=8.
REQ-033 One sub-module sync_fifo (push/pop, full/empty, head data) SHALL be instantiated twice, once per output port; routing, ready and counters stay in stream_demux.

Verification
REQ-034 Reset then idle: all outputs 0; after reset drops, in_ready_o=1 for sel 0 and 1.
REQ-035 Send 8'hA5 sel=0, 8'h3C sel=1, both readies 1: out0 shows A5 and out1 shows 3C one cycle after each acceptance; cnt0_o=1, cnt1_o=1.
REQ-036 out0_ready_i=0, send 8'h01, 8'h02, 8'h03 sel=0: first two accepted, in_ready_o=0 for third; raise ready -> out0 emits 01, 02, then 03 in order.
REQ-037 Hold out0 full, send 8'h77 sel=1: accepted immediately and emitted on out1 while out0 stalls.
REQ-038 Send 256 beats sel=1 with out1_ready_i=1: cnt1_o wraps to 0, cnt0_o stays 0.
REQ-039 Fill out1 with 8'h11, 8'h22, assert reset one cycle: out1_valid_o=0, counters 0, and 11/22 are never emitted.
